// File: rtl/cert_response_serializer.sv
// Serializes a captured CERTIFICATE response (header + payload) onto a valid/ready byte stream.
// Build option: define CERT_ERROR_RESPONSE_EN to emit a 4-byte error response; otherwise invalid frames are dropped.
module cert_response_serializer #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 256,
  parameter logic [7:0]  ERR_CODE          = 8'h01
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           Ack_in,
  input  logic                           Error_Invalid_Request,
  input  logic [31:0]                    header,
  input  logic [15:0]                    wLength,
  input  logic [MAX_PAYLOAD_BYTES*8-1:0] payload,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  output logic                           tx_last,
  output logic                           busy,
  output logic                           done,
  output logic                           dropped
);
  localparam int unsigned PW = MAX_PAYLOAD_BYTES * 8;
  localparam int unsigned IW = (MAX_PAYLOAD_BYTES > 1) ? $clog2(MAX_PAYLOAD_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, ERROR, DONE} state_t;

  state_t        state_q;
  logic          ack_q;
  logic [31:0]   hdr_q;
  logic [PW-1:0] pl_q;
  logic [15:0]   len_q;
  logic [15:0]   cnt_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          tx_last_q;
  logic          done_q;
  logic          dropped_q;

  logic          start;
  logic          oversize;
  logic [15:0]   cnt_inc;
  logic [15:0]   pl_k;
  logic [IW-1:0] byte_idx;
  logic [1:0]    sel;
  logic [7:0]    hdr_byte;
  logic [7:0]    pl_byte;

  assign start    = Ack_in & ~ack_q & (state_q == IDLE);
  assign oversize = wLength > 16'(MAX_PAYLOAD_BYTES);
  assign cnt_inc  = cnt_q + 16'd1;
  // Byte k of the certificate sits at byte lane (wLength-1-k) of the right-aligned bus.
  assign pl_k     = (state_q == PAYLOAD) ? cnt_inc : 16'd0;
  assign byte_idx = IW'(len_q - 16'd1 - pl_k);
  assign pl_byte  = pl_q[{byte_idx, 3'b000} +: 8];
  // First load of a 4-byte section presents index 0; afterwards the index after the transfer.
  assign sel      = tx_valid_q ? cnt_inc[1:0] : 2'd0;

  always_comb begin
    hdr_byte = hdr_q[31:24];
    case (sel)
      2'd1:    hdr_byte = hdr_q[23:16];
      2'd2:    hdr_byte = hdr_q[15:8];
      2'd3:    hdr_byte = hdr_q[7:0];
      default: hdr_byte = hdr_q[31:24];
    endcase
  end

`ifdef CERT_ERROR_RESPONSE_EN
  logic [7:0] err_byte;

  always_comb begin
    err_byte = hdr_q[31:24];
    case (sel)
      2'd1:    err_byte = 8'h7F;
      2'd2:    err_byte = ERR_CODE;
      2'd3:    err_byte = 8'h00;
      default: err_byte = hdr_q[31:24];
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      hdr_q      <= '0;
      pl_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      ack_q     <= Ack_in;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            hdr_q   <= header;
            pl_q    <= payload;
            len_q   <= wLength;
            cnt_q   <= '0;
            state_q <= (Error_Invalid_Request || oversize) ? ERROR : HEADER;
          end
        end
        HEADER: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= hdr_byte;
            tx_last_q  <= 1'b0;
          end else if (tx_ready) begin
            if (cnt_q == 16'd3) begin
              cnt_q <= '0;
              if (len_q == 16'd0) begin
                tx_valid_q <= 1'b0;
                tx_last_q  <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= DONE;
              end else begin
                tx_data_q <= pl_byte;
                tx_last_q <= (len_q == 16'd1);
                state_q   <= PAYLOAD;
              end
            end else begin
              cnt_q     <= cnt_inc;
              tx_data_q <= hdr_byte;
              tx_last_q <= (cnt_inc == 16'd3) && (len_q == 16'd0);
            end
          end
        end
        PAYLOAD: begin
          if (tx_valid_q && tx_ready) begin
            if (cnt_inc == len_q) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q     <= cnt_inc;
              tx_data_q <= pl_byte;
              tx_last_q <= (cnt_inc == len_q - 16'd1);
            end
          end
        end
`ifdef CERT_ERROR_RESPONSE_EN
        ERROR: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= err_byte;
            tx_last_q  <= 1'b0;
          end else if (tx_ready) begin
            if (cnt_q == 16'd3) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q     <= cnt_inc;
              tx_data_q <= err_byte;
              tx_last_q <= (cnt_inc == 16'd3);
            end
          end
        end
`else
        ERROR: begin
          dropped_q <= 1'b1;
          state_q   <= IDLE;
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign dropped  = dropped_q;
endmodule

// File: tb/tb_cert_response_serializer.sv
// Directed bench for cert_response_serializer; expects the error response when CERT_ERROR_RESPONSE_EN is defined.
module tb_cert_response_serializer;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          Ack_in = 1'b0;
  logic          Error_Invalid_Request = 1'b0;
  logic [31:0]   header = '0;
  logic [15:0]   wLength = '0;
  logic [2047:0] payload = '0;
  logic          tx_ready = 1'b1;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_last, busy, done, dropped;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_data [0:15];
  logic       got_last [0:15];
  int got_n, done_at, drop_at, first_valid_at, n_done, n_drop, stall_bad;
  bit any_valid;
  logic [3:0] bp_pat = 4'b1001;

  always #5 clk = ~clk;

  cert_response_serializer dut (
    .clk(clk), .reset_n(reset_n), .Ack_in(Ack_in),
    .Error_Invalid_Request(Error_Invalid_Request), .header(header),
    .wLength(wLength), .payload(payload), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .busy(busy), .done(done), .dropped(dropped)
  );

  // Called at a negedge; the start edge N is the next posedge.
  task automatic start_frame(input logic [31:0] h, input logic [15:0] len,
                             input logic [23:0] pl, input logic err, input logic hold);
    header = h;
    wLength = len;
    payload = '0;
    payload[23:0] = pl;
    Error_Invalid_Request = err;
    Ack_in = 1'b1;
    @(negedge clk);
    Ack_in = hold;
  endtask

  // Runs 'limit' cycles after the start edge, logging accepted bytes and pulses.
  task automatic collect(input int limit, input bit bp, input int pulse_at);
    logic pv, pl, rdy;
    logic [7:0] pd;
    for (int k = 0; k < 16; k++) begin
      got_data[k] = 'x;
      got_last[k] = 1'bx;
    end
    got_n = 0; done_at = 0; drop_at = 0; first_valid_at = 0;
    n_done = 0; n_drop = 0; stall_bad = 0; any_valid = 0;
    for (int i = 1; i <= limit; i++) begin
      rdy = bp ? bp_pat[(i - 1) % 4] : 1'b1;
      tx_ready = rdy;
      if (pulse_at != 0 && i == pulse_at) Ack_in = 1'b1;
      if (pulse_at != 0 && i == pulse_at + 1) Ack_in = 1'b0;
      pv = tx_valid; pd = tx_data; pl = tx_last;
      @(negedge clk);
      if (pv && rdy && got_n < 16) begin
        got_data[got_n] = pd;
        got_last[got_n] = pl;
        got_n++;
      end
      if (pv && !rdy && (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl)) stall_bad++;
      if (tx_valid === 1'b1) begin
        any_valid = 1;
        if (first_valid_at == 0) first_valid_at = i;
      end
      if (done === 1'b1) begin n_done++; if (done_at == 0) done_at = i; end
      if (dropped === 1'b1) begin n_drop++; if (drop_at == 0) drop_at = i; end
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00 ||
        busy !== 1'b0 || done !== 1'b0 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got v=%b l=%b d=%h b=%b dn=%b dr=%b exp all zero",
               tx_valid, tx_last, tx_data, busy, done, dropped);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal;
    logic [7:0] exp [0:6];
    exp = '{8'h01, 8'h82, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    start_frame(32'h0182_0000, 16'd3, 24'hAABBCC, 1'b0, 1'b0);
    collect(20, 1'b0, 0);
    checks++;
    if (got_n !== 7) begin errors++; $display("FAIL normal_count got %0d exp 7", got_n); end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got_data[k] !== exp[k] || got_last[k] !== (k == 6)) begin
        errors++;
        $display("FAIL normal_byte%0d got %h last=%b exp %h last=%b", k, got_data[k], got_last[k], exp[k], (k == 6));
      end
    end
    checks++;
    if (first_valid_at !== 1) begin errors++; $display("FAIL normal_latency got %0d exp 1", first_valid_at); end
    checks++;
    if (done_at !== 8 || n_done !== 1) begin
      errors++; $display("FAIL normal_done got at=%0d n=%0d exp at=8 n=1", done_at, n_done);
    end
    checks++;
    if (busy !== 1'b0 || n_drop !== 0) begin
      errors++; $display("FAIL normal_idle got busy=%b drops=%0d exp 0 0", busy, n_drop);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [0:6];
    exp = '{8'h01, 8'h82, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    start_frame(32'h0182_0000, 16'd3, 24'hAABBCC, 1'b0, 1'b0);
    collect(40, 1'b1, 0);
    checks++;
    if (got_n !== 7) begin errors++; $display("FAIL bp_count got %0d exp 7", got_n); end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got_data[k] !== exp[k] || got_last[k] !== (k == 6)) begin
        errors++;
        $display("FAIL bp_byte%0d got %h last=%b exp %h last=%b", k, got_data[k], got_last[k], exp[k], (k == 6));
      end
    end
    checks++;
    if (stall_bad !== 0 || n_done !== 1) begin
      errors++; $display("FAIL bp_stall got unstable=%0d done=%0d exp 0 1", stall_bad, n_done);
    end
  endtask

  task automatic test_zero_len;
    logic [7:0] exp [0:3];
    exp = '{8'h01, 8'h82, 8'h00, 8'h00};
    start_frame(32'h0182_0000, 16'd0, 24'hAABBCC, 1'b0, 1'b0);
    collect(15, 1'b0, 0);
    checks++;
    if (got_n !== 4) begin errors++; $display("FAIL zero_count got %0d exp 4", got_n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_data[k] !== exp[k] || got_last[k] !== (k == 3)) begin
        errors++;
        $display("FAIL zero_byte%0d got %h last=%b exp %h last=%b", k, got_data[k], got_last[k], exp[k], (k == 3));
      end
    end
    checks++;
    if (done_at !== 5 || n_done !== 1) begin
      errors++; $display("FAIL zero_done got at=%0d n=%0d exp at=5 n=1", done_at, n_done);
    end
  endtask

  task automatic test_error(input logic err, input logic [15:0] len, input string nm);
    start_frame(32'h0182_0100, len, 24'hAABBCC, err, 1'b0);
    collect(15, 1'b0, 0);
    Error_Invalid_Request = 1'b0;
`ifdef CERT_ERROR_RESPONSE_EN
    begin
      logic [7:0] exp [0:3];
      exp = '{8'h01, 8'h7F, 8'h01, 8'h00};
      checks++;
      if (got_n !== 4) begin errors++; $display("FAIL %s_count got %0d exp 4", nm, got_n); end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_data[k] !== exp[k] || got_last[k] !== (k == 3)) begin
          errors++;
          $display("FAIL %s_byte%0d got %h last=%b exp %h last=%b", nm, k, got_data[k], got_last[k], exp[k], (k == 3));
        end
      end
      checks++;
      if (done_at !== 5 || n_done !== 1 || n_drop !== 0) begin
        errors++; $display("FAIL %s_done got at=%0d n=%0d drops=%0d exp 5 1 0", nm, done_at, n_done, n_drop);
      end
    end
`else
    checks++;
    if (any_valid !== 1'b0 || got_n !== 0) begin
      errors++; $display("FAIL %s_novalid got valid_seen=%b bytes=%0d exp 0 0", nm, any_valid, got_n);
    end
    checks++;
    if (n_drop !== 1 || drop_at !== 1 || n_done !== 0) begin
      errors++; $display("FAIL %s_dropped got n=%0d at=%0d done=%0d exp 1 1 0", nm, n_drop, drop_at, n_done);
    end
`endif
  endtask

  task automatic test_ack_held;
    start_frame(32'h0182_0000, 16'd3, 24'hAABBCC, 1'b0, 1'b1);
    collect(30, 1'b0, 0);
    Ack_in = 1'b0;
    checks++;
    if (got_n !== 7 || n_done !== 1) begin
      errors++; $display("FAIL ack_held got bytes=%0d done=%0d exp 7 1", got_n, n_done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pulse_busy;
    start_frame(32'h0182_0000, 16'd3, 24'hAABBCC, 1'b0, 1'b0);
    collect(30, 1'b0, 3);
    checks++;
    if (got_n !== 7 || n_done !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL pulse_busy got bytes=%0d done=%0d busy=%b exp 7 1 0", got_n, n_done, busy);
    end
  endtask

  task automatic test_reset_midframe;
    int nd;
    bit vseen;
    start_frame(32'h0182_0000, 16'd3, 24'hAABBCC, 1'b0, 1'b0);
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++; $display("FAIL mid_third_byte got v=%b d=%h exp 1 00", tx_valid, tx_data);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_async_reset got v=%b l=%b b=%b exp 0 0 0", tx_valid, tx_last, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    vseen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
      if (tx_valid === 1'b1) vseen = 1;
    end
    checks++;
    if (busy !== 1'b0 || nd !== 0 || vseen !== 1'b0) begin
      errors++; $display("FAIL mid_after_release got busy=%b done=%0d valid=%b exp 0 0 0", busy, nd, vseen);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_backpressure;
    test_zero_len;
    test_error(1'b1, 16'd3, "err_flag");
    repeat (2) @(negedge clk);
    test_error(1'b0, 16'd257, "oversize");
    repeat (2) @(negedge clk);
    test_ack_held;
    test_pulse_busy;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cert_response_serializer.md
# cert_response_serializer

Byte-stream serializer sitting directly downstream of the certificate-answer stage. Captures the registered header, payload and wLength that stage presents alongside its acknowledge, then emits the CERTIFICATE response one byte per accepted handshake on a valid/ready byte interface toward the USB transport layer. Invalid requests flagged upstream become a fixed 4-byte error response. Busy/done status lets the authentication controller sequence the next request.

## Interface
- `MAX_PAYLOAD_BYTES`, default 256: capacity of the payload bus in bytes. Must equal (`MSG_LEN`-32)/8.
- `ERR_CODE`, default 8'h01: Param1 byte of the error response (InvalidRequest).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Ack_in`  in  1  level acknowledge from the answer stage; a rising edge starts a frame.
- `Error_Invalid_Request`  in  1  sampled with `Ack_in`; selects the error response.
- `header`  in  32  {protocol version, command, Param1, Param2}; byte [31:24] is sent first.
- `wLength`  in  16  payload byte count.
- `payload`  in  `MSG_LEN`-32  certificate bytes, right-aligned.
- `tx_data`  out  8  current byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte when `tx_valid` and `tx_ready` are both high.
- `tx_last`  out  1  current byte is the final byte of the frame.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last byte is accepted.
- `dropped`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, ERROR, DONE.
- `ack_q` registers `Ack_in` every cycle. Start condition: `Ack_in`=1, `ack_q`=0, and state is IDLE.
- On start, the block latches `header`, `payload`, `wLength` and `Error_Invalid_Request` into shadow registers and clears the 16-bit byte counter `cnt`. Next state:
  - ERROR if the error flag is set or `wLength` > `MAX_PAYLOAD_BYTES`;
  - HEADER otherwise.
- HEADER: `tx_data` = shadow header byte (3-`cnt`).
  - After the transfer with `cnt`=3: go to PAYLOAD with `cnt` cleared, or go to DONE if `wLength`=0.
- PAYLOAD: payload byte k is `payload[(wLength-1-k)*8 +: 8]`, so k=0 is the most significant certificate byte.
  - After the transfer with `cnt`=`wLength`-1: go to DONE.
- ERROR: sends 4 bytes, in order: `header[31:24]`, 8'h7F (ERROR command), `ERR_CODE`, 8'h00. Then go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `cnt` advances only on a transfer.
- `tx_last` = `tx_valid` and final-byte condition. Final byte is:
  - header byte 3 when `wLength`=0;
  - payload byte `wLength`-1;
  - error byte 3.
- A rising edge of `Ack_in` while `busy` is ignored and not queued. `Ack_in` held high never retriggers a frame.
- Total frame length is 4+`wLength` bytes, or 4 for an error response.

## Timing
- Reset values: `tx_valid`=0, `tx_last`=0, `tx_data`=8'h00, `busy`=0, `done`=0, `dropped`=0, state=IDLE, `ack_q`=0. Asserting `reset_n` mid-frame aborts the frame immediately; no `done` is generated.
- Latency: start sampled at edge N; `tx_valid`=1 with the first byte from edge N+1.
- With `tx_ready` held at 1, one byte is transferred per cycle. `done` pulses at the edge following the last transfer.
- While `tx_valid`=1 and `tx_ready`=0: `tx_data`, `tx_last` and `tx_valid` hold stable. `tx_valid` never drops before the transfer completes.
- `tx_valid` is 0 in IDLE and DONE. Back-to-back frames therefore have a gap of at least 2 cycles.

## Configuration
- `CERT_ERROR_RESPONSE_EN` defined: ERROR state behaves as described under Operation.
- `CERT_ERROR_RESPONSE_EN` undefined: ERROR state is not compiled. On start with the error condition:
  - the frame is discarded with no output bytes;
  - `dropped` pulses at edge N+1;
  - the FSM returns to IDLE without `done`.
- `dropped` stays 0 when the macro is defined.

## Test plan
- Normal frame: header 32'h01_82_00_00, `wLength`=3, low payload bytes 24'hAABBCC, `tx_ready`=1 → bytes 01,82,00,00,AA,BB,CC; `tx_last` on CC; `done` pulses at the 8th edge after start.
- Backpressure: same frame, `tx_ready` toggled 1,0,0,1,… → no byte is lost or duplicated, and `tx_data` is stable during stalls.
- Zero length: `wLength`=0 → exactly 4 header bytes, with `tx_last` on byte 4.
- Error response: `Error_Invalid_Request`=1, header 32'h01_82_01_00.
  - Macro defined → 01,7F,01,00, then `done`.
  - Macro undefined → no `tx_valid`; `dropped` pulses once.
- Oversize: `wLength`=257 → treated as an error, with the same response as the previous scenario.
- Retrigger and reset:
  - `Ack_in` held high across a frame → exactly one frame.
  - A second `Ack_in` pulse while busy → ignored.
  - `reset_n` low at the 3rd byte → `tx_valid`=0 asynchronously, and `busy`=0 after release.
